// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter sharing one registered bitwise logic unit (AND/OR/XOR/NOR)
// between two valid/ready requesters. One result register, tagged with the
// issuing requester's ID, drained through a valid/ready response channel.
module logic_unit_arbiter #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [1:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [1:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_data,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);
    typedef enum logic {IDLE = 1'b0, FULL = 1'b1} state_e;

    state_e           state_q;
    logic             ptr_q;    // requester favoured when both are valid
    logic             id_q;
    logic [WIDTH-1:0] data_q;
    logic [CNT_W-1:0] cnt_q;

    // Requester ports gathered into index-able packed arrays
    logic [1:0]            vld;
    logic [1:0][1:0]       op_arr;
    logic [1:0][WIDTH-1:0] a_arr;
    logic [1:0][WIDTH-1:0] b_arr;

    assign vld    = {req1_valid, req0_valid};
    assign op_arr = {req1_op, req0_op};
    assign a_arr  = {req1_a, req0_a};
    assign b_arr  = {req1_b, req0_b};

    logic             drain;
    logic             slot_free;
    logic             grant;
    logic             accept;
    logic [WIDTH-1:0] res_d;

    assign drain = (state_q == FULL) && rsp_ready;
    // Gate on rst_n so the readies drop immediately while reset is held,
    // not only once the state register has been cleared.
    assign slot_free = rst_n && ((state_q == IDLE) || rsp_ready);

    // Winner: a lone valid requester, else the favoured one
    always_comb begin
        grant = 1'b0;
        if (vld[0] && vld[1]) grant = ptr_q;
        else if (vld[1])      grant = 1'b1;
    end

    assign req0_ready = slot_free && vld[0] && !grant;
    assign req1_ready = slot_free && vld[1] &&  grant;
    assign accept     = req0_ready || req1_ready;

    // Single shared logic unit fed by the winner's operands
    always_comb begin
        res_d = '0;
        unique case (op_arr[grant])
            2'b00: res_d = a_arr[grant] & b_arr[grant];
            2'b01: res_d = a_arr[grant] | b_arr[grant];
            2'b10: res_d = a_arr[grant] ^ b_arr[grant];
            2'b11: res_d = ~(a_arr[grant] | b_arr[grant]);
            default: res_d = '0;
        endcase
    end

    // Result-slot FSM: load on accept, empty on a drain with no refill
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= 1'b0;
            id_q    <= 1'b0;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            if (drain) cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            if (accept) begin
                state_q <= FULL;
                data_q  <= res_d;
                id_q    <= grant;
                ptr_q   <= ~grant;
            end else if (drain) begin
                state_q <= IDLE;
            end
        end
    end

    assign rsp_valid = (state_q == FULL);
    assign busy      = (state_q == FULL);
    assign rsp_id    = id_q;
    assign rsp_data  = data_q;
    assign op_count  = cnt_q;

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Bench for logic_unit_arbiter: directed scenarios plus a randomized run, all
// checked against a transaction-level model of the result slot.
module tb_logic_unit_arbiter;
    localparam int W  = 32;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req0_valid = 1'b0, req1_valid = 1'b0;
    logic [1:0]    req0_op = 2'd0, req1_op = 2'd0;
    logic [W-1:0]  req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic          rsp_ready = 1'b0;
    logic          req0_ready, req1_ready, rsp_valid, rsp_id, busy;
    logic [W-1:0]  rsp_data;
    logic [CW-1:0] op_count;

    int n_cmp = 0;
    int n_err = 0;

    logic_unit_arbiter #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .busy(busy), .op_count(op_count)
    );

    always #5 clk = ~clk;

    // Reference model: contents of the single result slot and the fairness token
    bit         m_full, m_id, m_ptr;
    logic [W-1:0] m_data;
    int         m_cnt;
    bit         acc0_last, acc1_last;

    function automatic logic [W-1:0] lop(logic [1:0] op, logic [W-1:0] a, logic [W-1:0] b);
        case (op)
            2'd0:    return a & b;
            2'd1:    return a | b;
            2'd2:    return a ^ b;
            default: return ~(a | b);
        endcase
    endfunction

    // Who the model says is accepted this cycle (-1 for nobody)
    function automatic int m_winner();
        bit free;
        free = rst_n && (!m_full || rsp_ready);
        if (!free) return -1;
        if (req0_valid && req1_valid) return m_ptr ? 1 : 0;
        if (req0_valid) return 0;
        if (req1_valid) return 1;
        return -1;
    endfunction

    task automatic m_reset();
        m_full = 0; m_id = 0; m_ptr = 0; m_data = '0; m_cnt = 0;
        acc0_last = 0; acc1_last = 0;
    endtask

    // Advance one clock; model consumes the inputs seen before the edge
    task automatic adv();
        int  w;
        bit  drain;
        @(negedge clk);
        w = m_winner();
        drain = m_full && rsp_ready;
        if (drain) m_cnt = (m_cnt + 1) % (1 << CW);
        if (w == 0) begin
            m_data = lop(req0_op, req0_a, req0_b); m_id = 0; m_full = 1; m_ptr = 1;
        end else if (w == 1) begin
            m_data = lop(req1_op, req1_a, req1_b); m_id = 1; m_full = 1; m_ptr = 0;
        end else if (drain) begin
            m_full = 0;
        end
        acc0_last = (w == 0);
        acc1_last = (w == 1);
        @(posedge clk); #1;
    endtask

    task automatic set_req(int k, bit v, logic [1:0] op, logic [W-1:0] a, logic [W-1:0] b);
        if (k == 0) begin req0_valid = v; req0_op = op; req0_a = a; req0_b = b; end
        else        begin req1_valid = v; req1_op = op; req1_a = a; req1_b = b; end
    endtask

    task automatic do_reset();
        req0_valid = 0; req1_valid = 0; rsp_ready = 0;
        rst_n = 0;
        m_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
    endtask

    task automatic test_reset();
        set_req(0, 1, 2'd1, 32'h1, 32'h2);
        set_req(1, 1, 2'd1, 32'h3, 32'h4);
        rsp_ready = 1;
        rst_n = 0;
        m_reset();
        #1;
        n_cmp++; if (req0_ready !== 1'b0) begin n_err++; $display("FAIL reset_rdy0 got %b want 0", req0_ready); end
        n_cmp++; if (req1_ready !== 1'b0) begin n_err++; $display("FAIL reset_rdy1 got %b want 0", req1_ready); end
        n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", rsp_valid); end
        n_cmp++; if (rsp_data !== 32'h0) begin n_err++; $display("FAIL reset_data got %h want 0", rsp_data); end
        n_cmp++; if (op_count !== 4'd0) begin n_err++; $display("FAIL reset_cnt got %0d want 0", op_count); end
        n_cmp++; if (rsp_id !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL reset_id_busy got %b%b want 00", rsp_id, busy); end
        do_reset();
    endtask

    task automatic test_single_op();
        rsp_ready = 1;
        set_req(0, 1, 2'b01, 32'hAAAA_AAAA, 32'h5555_5555);
        #1;
        n_cmp++; if (req0_ready !== 1'b1) begin n_err++; $display("FAIL single_rdy got %b want 1", req0_ready); end
        adv();
        req0_valid = 0;
        n_cmp++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL single_valid got %b want 1", rsp_valid); end
        n_cmp++; if (rsp_id !== 1'b0) begin n_err++; $display("FAIL single_id got %b want 0", rsp_id); end
        n_cmp++; if (rsp_data !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL single_data got %h want ffffffff", rsp_data); end
        adv();
        n_cmp++; if (op_count !== 4'd1) begin n_err++; $display("FAIL single_cnt got %0d want 1", op_count); end
        n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL single_empty got %b want 0", rsp_valid); end
    endtask

    task automatic test_opcodes();
        logic [W-1:0] exp_t [4];
        exp_t[0] = 32'h0F0F_0000; exp_t[1] = 32'hFFFF_0F0F;
        exp_t[2] = 32'hF0F0_0F0F; exp_t[3] = 32'h0000_F0F0;
        rsp_ready = 1;
        for (int op = 0; op < 4; op++) begin
            set_req(1, 1, 2'(op), 32'hFFFF_0000, 32'h0F0F_0F0F);
            adv();
            n_cmp++; if (rsp_data !== exp_t[op] || rsp_id !== 1'b1)
                begin n_err++; $display("FAIL opcode%0d got %h/%b want %h/1", op, rsp_data, rsp_id, exp_t[op]); end
        end
        req1_valid = 0;
        adv();
    endtask

    task automatic test_contention();
        do_reset();
        rsp_ready = 1;
        for (int i = 0; i < 6; i++) begin
            set_req(0, 1, 2'($urandom_range(3)), $urandom, $urandom);
            set_req(1, 1, 2'($urandom_range(3)), $urandom, $urandom);
            adv();
            n_cmp++; if (rsp_valid !== 1'b1 || rsp_id !== 1'(i % 2))
                begin n_err++; $display("FAIL contend_grant%0d got v%b id%b want v1 id%0d", i, rsp_valid, rsp_id, i % 2); end
        end
        req0_valid = 0; req1_valid = 0;
        adv();
        n_cmp++; if (op_count !== 4'd6) begin n_err++; $display("FAIL contend_cnt got %0d want 6", op_count); end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] held;
        do_reset();
        rsp_ready = 1;
        set_req(0, 1, 2'd2, 32'hDEAD_BEEF, 32'h0000_FFFF);
        set_req(1, 1, 2'd0, 32'h1234_5678, 32'hFFFF_0000);
        adv();
        held = 32'hDEAD_4110;
        rsp_ready = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_cmp++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0)
                begin n_err++; $display("FAIL stall_rdy%0d got %b%b want 00", i, req0_ready, req1_ready); end
            adv();
            n_cmp++; if (rsp_data !== held || rsp_id !== 1'b0 || rsp_valid !== 1'b1)
                begin n_err++; $display("FAIL stall_hold%0d got %h/%b want %h/0", i, rsp_data, rsp_id, held); end
        end
        rsp_ready = 1;
        #1;
        n_cmp++; if (req1_ready !== 1'b1 || req0_ready !== 1'b0)
            begin n_err++; $display("FAIL release_rdy got %b%b want 10", req1_ready, req0_ready); end
        adv();
        n_cmp++; if (rsp_id !== 1'b1 || rsp_data !== 32'h1234_0000)
            begin n_err++; $display("FAIL release_rsp got %h/%b want 12340000/1", rsp_data, rsp_id); end
        req0_valid = 0; req1_valid = 0;
        adv();
    endtask

    task automatic test_reset_mid();
        do_reset();
        rsp_ready = 0;
        set_req(0, 1, 2'd2, 32'h1234_5678, 32'h0);
        adv();
        req0_valid = 0;
        n_cmp++; if (rsp_data !== 32'h1234_5678) begin n_err++; $display("FAIL mid_load got %h want 12345678", rsp_data); end
        set_req(0, 1, 2'd0, 32'hFFFF_FFFF, 32'h0000_00A5);
        set_req(1, 1, 2'd1, 32'h0, 32'h0000_005A);
        #2 rst_n = 0;
        m_reset();
        #1;
        n_cmp++; if (rsp_valid !== 1'b0 || rsp_data !== 32'h0)
            begin n_err++; $display("FAIL mid_async got v%b %h want v0 0", rsp_valid, rsp_data); end
        n_cmp++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0)
            begin n_err++; $display("FAIL mid_rdy got %b%b want 00", req0_ready, req1_ready); end
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        rsp_ready = 1;
        #1;
        n_cmp++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0)
            begin n_err++; $display("FAIL mid_first_rdy got %b%b want 10", req0_ready, req1_ready); end
        adv();
        n_cmp++; if (rsp_id !== 1'b0 || rsp_data !== 32'h0000_00A5)
            begin n_err++; $display("FAIL mid_first_rsp got %h/%b want 000000a5/0", rsp_data, rsp_id); end
        req0_valid = 0; req1_valid = 0;
        adv();
    endtask

    task automatic test_wrap();
        do_reset();
        rsp_ready = 1;
        for (int j = 1; j <= 18; j++) begin
            set_req(0, j <= 17, 2'($urandom_range(3)), $urandom, $urandom);
            adv();
            n_cmp++; if (op_count !== 4'((j - 1) % 16))
                begin n_err++; $display("FAIL wrap_cnt%0d got %0d want %0d", j, op_count, (j - 1) % 16); end
        end
    endtask

    task automatic test_random();
        int wait0, wait1;
        do_reset();
        wait0 = 0; wait1 = 0;
        for (int i = 0; i < 400; i++) begin
            // Requesters keep an unaccepted request steady, occasionally withdrawing it
            if (!(req0_valid && !acc0_last) || $urandom_range(19) == 0)
                set_req(0, $urandom_range(9) < 6, 2'($urandom_range(3)), $urandom, $urandom);
            if (!(req1_valid && !acc1_last) || $urandom_range(19) == 0)
                set_req(1, $urandom_range(9) < 6, 2'($urandom_range(3)), $urandom, $urandom);
            rsp_ready = $urandom_range(9) < 7;
            #1;
            n_cmp++; if (req0_ready !== (m_winner() == 0) || req1_ready !== (m_winner() == 1))
                begin n_err++; $display("FAIL rnd_rdy%0d got %b%b want %b%b", i, req1_ready, req0_ready, m_winner() == 1, m_winner() == 0); end
            // Fairness: a continuously pending requester is served within 2 free slots
            if (req0_valid && rsp_ready && m_winner() != 0) wait0++; else wait0 = 0;
            if (req1_valid && rsp_ready && m_winner() != 1) wait1++; else wait1 = 0;
            n_cmp++; if (wait0 > 1 || wait1 > 1)
                begin n_err++; $display("FAIL rnd_starve%0d got waits %0d/%0d want <=1", i, wait0, wait1); end
            adv();
            n_cmp++; if (rsp_valid !== m_full || busy !== m_full || rsp_data !== m_data ||
                         rsp_id !== m_id || op_count !== 4'(m_cnt))
                begin n_err++; $display("FAIL rnd_state%0d got v%b b%b %h id%b c%0d want v%b %h id%b c%0d",
                                        i, rsp_valid, busy, rsp_data, rsp_id, op_count, m_full, m_data, m_id, m_cnt); end
        end
        req0_valid = 0; req1_valid = 0;
    endtask

    initial begin
        do_reset();
        test_reset();
        test_single_op();
        test_opcodes();
        test_contention();
        test_back_to_back();
        test_reset_mid();
        test_wrap();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/logic_unit_arbiter.md
Name: logic_unit_arbiter

Overview:
Shares one registered 32-bit bitwise logic unit (AND/OR/XOR/NOR) between two requesters, e.g. the ALU issue path and the branch/compare path of the Mini-MIPS datapath.
Round-robin arbitration. Valid/ready handshake on both request ports. A single response channel is tagged with the requester ID.
Sustains one operation per cycle when the response consumer never stalls.

Parameters:
WIDTH, 32, operand/result width in bits
CNT_W, 16, width of completed-operation counter

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
req0_valid  input  1  requester 0 has an operation
req0_ready  output  1  requester 0 operation accepted this cycle
req0_op  input  2  requester 0 opcode
req0_a  input  WIDTH  requester 0 operand A
req0_b  input  WIDTH  requester 0 operand B
req1_valid  input  1  requester 1 has an operation
req1_ready  output  1  requester 1 operation accepted this cycle
req1_op  input  2  requester 1 opcode
req1_a  input  WIDTH  requester 1 operand A
req1_b  input  WIDTH  requester 1 operand B
rsp_valid  output  1  result available
rsp_ready  input  1  consumer takes result
rsp_id  output  1  requester that issued the result
rsp_data  output  WIDTH  result
busy  output  1  result register occupied (equals rsp_valid)
op_count  output  CNT_W  completed responses since reset

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- Opcodes: 00 = a AND b, 01 = a OR b, 10 = a XOR b, 11 = NOT(a OR b). Result is exactly WIDTH bits; there is no carry or sign.
- Reset: rsp_valid=0, rsp_id=0, rsp_data=0, op_count=0, priority pointer=0, FSM=IDLE. Reset mid-operation discards the held result. req*_ready go low combinationally while rst_n=0.
- FSM states:
  - IDLE: result register empty.
  - FULL: result held, rsp_valid=1.
- Slot free (slot_free): FSM=IDLE, or FSM=FULL with rsp_ready=1 (same-cycle drain and refill).
- Arbitration (combinational):
  - Only req0_valid high: grant 0.
  - Only req1_valid high: grant 1.
  - Both high: grant the requester selected by the priority pointer.
  - reqk_ready = slot_free AND grant==k AND reqk_valid. At most one ready is high per cycle.
- Accept: reqk_valid & reqk_ready at clock edge.
  - Register rsp_data = op(a,b) and rsp_id = k.
  - FSM becomes FULL.
  - Priority pointer becomes the other requester (1-k).
  - Latency: rsp_valid high on the cycle after accept.
- Pointer update: occurs only on accept, never on idle cycles.
- Drain: rsp_valid & rsp_ready.
  - op_count increments by 1, wrapping from 2^CNT_W-1 to 0.
  - If no accept occurs in the same cycle, FSM becomes IDLE and rsp_data/rsp_id hold their last values.
- Drain plus accept in the same cycle: FSM stays FULL, new data is loaded, and op_count still increments.
- Stall: FULL with rsp_ready=0.
  - rsp_data and rsp_id are stable; no ready is asserted.
  - Requesters must hold valid and operands (AXI-style). The arbiter does not latch requests.
- A requester dropping valid before acceptance is legal; no grant is recorded.
- Throughput: 1 op/cycle with rsp_ready held high. Under continuous contention, grants alternate 0,1,0,1.
- Starvation bound: a valid requester is granted within 2 slot-free cycles.

Test Plan:
- Reset then single op: req0 op=01, a=AAAA_AAAA, b=5555_5555, rsp_ready=1 -> next cycle rsp_valid=1, rsp_id=0, rsp_data=FFFF_FFFF; op_count=1 after the drain edge.
- All opcodes on req1 with a=FFFF_0000, b=0F0F_0F0F -> AND 0F0F_0000, OR FFFF_0F0F, XOR F0F0_0F0F, NOR 0000_F0F0, all rsp_id=1.
- Contention: both valid for 6 cycles with rsp_ready=1 -> grant order 0,1,0,1,0,1, one response per cycle, op_count=6.
- Backpressure: rsp_ready=0 for 4 cycles while both requests are valid -> rsp_data is stable, req0_ready=req1_ready=0 throughout. When rsp_ready rises, the pending requester is accepted in that same cycle with no bubble.
- Reset mid-operation: assert rst_n=0 while FULL with rsp_data=1234_5678 -> rsp_valid=0 and rsp_data=0 immediately (asynchronously). After release, the first contended grant goes to requester 0.
- Counter wrap: with CNT_W=4, complete 17 ops -> op_count sequence reaches 15, then 0, then 1.
